avm_burst_read_engine: RTL and testbench

//   Parametrised Avalon-MM burst read master for the SDRAM memif read path.
//   An edge on an asynchronous start trigger launches NUM_BURSTS consecutive bursts of BURST_LEN beats.

---
 rtl/avm_burst_read_engine.sv | 162 ++++++++++++++++
 tb/tb_avm_burst_read_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_burst_read_engine.sv
// Avalon-MM burst read master: a synchronised start edge launches a run of fixed-length bursts,
// one outstanding at a time, forwarding each returned beat as a registered data/valid stream.
module avm_burst_read_engine #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned BURST_W   = 8,
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned NBURST_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_trigger,
    input  logic [ADDR_W-1:0]   base_addr_in,
    input  logic [NBURST_W-1:0] num_bursts_in,
    input  logic                avl_wait_req_in,
    input  logic                avl_read_valid_in,
    input  logic [DATA_W-1:0]   avl_rdata_in,
    output logic                avl_read_out,
    output logic [BURST_W-1:0]  avl_size_out,
    output logic [ADDR_W-1:0]   avl_addr_out,
    output logic [DATA_W-1:0]   rd_data_out,
    output logic                rd_valid_out,
    output logic                busy_out,
    output logic                done_out
);

    localparam int unsigned          BEAT_W    = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]    ADDR_STEP = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {StIdle, StIssue, StData, StFin} state_e;

    state_e               r_state, w_state_next;
    logic                 r_sync_meta, r_sync_s1, r_sync_s2;
    logic                 r_read, w_read_next;
    logic [ADDR_W-1:0]    r_addr, w_addr_next;
    logic [DATA_W-1:0]    r_rd_data, w_rd_data_next;
    logic                 r_rd_valid, w_rd_valid_next;
    logic                 r_busy, w_busy_next;
    logic                 r_done, w_done_next;
    logic [BEAT_W-1:0]    r_beat_cnt, w_beat_cnt_next;
    logic [NBURST_W-1:0]  r_bursts_left, w_bursts_left_next;
    logic                 w_launch;
    logic                 w_beat;

    // Synchroniser resets to 1 so a trigger held high through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 1'b1;
            r_sync_s1   <= 1'b1;
            r_sync_s2   <= 1'b1;
        end else begin
            r_sync_meta <= start_trigger;
            r_sync_s1   <= r_sync_meta;
            r_sync_s2   <= r_sync_s1;
        end
    end

    assign w_launch = r_sync_s1 & ~r_sync_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_read        <= 1'b0;
            r_addr        <= '0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_beat_cnt    <= '0;
            r_bursts_left <= '0;
        end else begin
            r_state       <= w_state_next;
            r_read        <= w_read_next;
            r_addr        <= w_addr_next;
            r_rd_data     <= w_rd_data_next;
            r_rd_valid    <= w_rd_valid_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_beat_cnt    <= w_beat_cnt_next;
            r_bursts_left <= w_bursts_left_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_read_next        = r_read;
        w_addr_next        = r_addr;
        w_rd_data_next     = r_rd_data;
        w_rd_valid_next    = 1'b0;
        w_busy_next        = r_busy;
        w_done_next        = 1'b0;
        w_beat_cnt_next    = r_beat_cnt;
        w_bursts_left_next = r_bursts_left;
        w_beat             = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_launch) begin
                    w_bursts_left_next = num_bursts_in;
                    if (num_bursts_in == '0) begin
                        w_done_next  = 1'b1;
                        w_state_next = StFin;
                    end else begin
                        w_read_next     = 1'b1;
                        w_addr_next     = base_addr_in;
                        w_busy_next     = 1'b1;
                        w_beat_cnt_next = '0;
                        w_state_next    = StIssue;
                    end
                end
            end
            StIssue: begin
                // A beat arriving in the accept cycle already belongs to this burst.
                if (!avl_wait_req_in) begin
                    w_read_next  = 1'b0;
                    w_state_next = StData;
                    w_beat       = avl_read_valid_in;
                end
            end
            StData: begin
                w_beat = avl_read_valid_in;
            end
            StFin: begin
                w_busy_next  = 1'b0;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (w_beat) begin
            w_rd_data_next  = avl_rdata_in;
            w_rd_valid_next = 1'b1;
            if (r_beat_cnt == LAST_BEAT) begin
                w_beat_cnt_next = '0;
                if (r_bursts_left != NBURST_W'(1)) begin
                    w_bursts_left_next = r_bursts_left - NBURST_W'(1);
                    w_addr_next        = r_addr + ADDR_STEP;
                    w_read_next        = 1'b1;
                    w_state_next       = StIssue;
                end else begin
                    w_bursts_left_next = '0;
                    w_done_next        = 1'b1;
                    w_state_next       = StFin;
                end
            end else begin
                w_beat_cnt_next = r_beat_cnt + BEAT_W'(1);
            end
        end
    end

    assign avl_read_out = r_read;
    assign avl_size_out = BURST_W'(BURST_LEN);
    assign avl_addr_out = r_addr;
    assign rd_data_out  = r_rd_data;
    assign rd_valid_out = r_rd_valid;
    assign busy_out     = r_busy;
    assign done_out     = r_done;

endmodule

// File: tb/tb_avm_burst_read_engine.sv
// Bench for avm_burst_read_engine: table of burst runs against a simple slave model,
// plus hand-written reset, zero-burst and mid-run-reset sequences.
module tb_avm_burst_read_engine;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 25;
    localparam int unsigned BURST_W   = 8;
    localparam int unsigned BURST_LEN = 32;
    localparam int unsigned NBURST_W  = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                start_trigger;
    logic [ADDR_W-1:0]   base_addr_in;
    logic [NBURST_W-1:0] num_bursts_in;
    logic                avl_wait_req_in;
    logic                avl_read_valid_in;
    logic [DATA_W-1:0]   avl_rdata_in;
    logic                avl_read_out;
    logic [BURST_W-1:0]  avl_size_out;
    logic [ADDR_W-1:0]   avl_addr_out;
    logic [DATA_W-1:0]   rd_data_out;
    logic                rd_valid_out;
    logic                busy_out;
    logic                done_out;

    always #5 clk = ~clk;

    avm_burst_read_engine #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_W   (BURST_W),
        .BURST_LEN (BURST_LEN),
        .NBURST_W  (NBURST_W)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .start_trigger     (start_trigger),
        .base_addr_in      (base_addr_in),
        .num_bursts_in     (num_bursts_in),
        .avl_wait_req_in   (avl_wait_req_in),
        .avl_read_valid_in (avl_read_valid_in),
        .avl_rdata_in      (avl_rdata_in),
        .avl_read_out      (avl_read_out),
        .avl_size_out      (avl_size_out),
        .avl_addr_out      (avl_addr_out),
        .rd_data_out       (rd_data_out),
        .rd_valid_out      (rd_valid_out),
        .busy_out          (busy_out),
        .done_out          (done_out)
    );

    typedef struct {
        logic [ADDR_W-1:0]   base;
        logic [NBURST_W-1:0] num;
        int                  wait_cyc;
        int                  gap;
        bit                  retrig;
        bit                  stray;
        logic [ADDR_W-1:0]   exp_last_addr;
        int                  exp_beats;
        int                  exp_cmds;
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int idx, input int seed);
        return DATA_W'(idx * 257 + seed * 4951 + 23040);
    endfunction

    task automatic do_run(input vec_t v, input int seed);
        int                cyc;
        int                cmds;
        int                beats;
        int                dones;
        int                rd_hi;
        int                sent;
        int                to_send;
        int                wait_left;
        int                gap_cnt;
        int                first_read_cyc;
        int                tail;
        bit                in_cmd;
        bit                done_seen;
        logic [ADDR_W-1:0] exp_addr;
        logic [ADDR_W-1:0] last_addr;
        cyc = 0; cmds = 0; beats = 0; dones = 0; rd_hi = 0; sent = 0; to_send = 0;
        wait_left = 0; gap_cnt = 0; first_read_cyc = -1; tail = 0;
        in_cmd = 0; done_seen = 0; exp_addr = '0; last_addr = '0;

        @(negedge clk);
        start_trigger = 1'b0; avl_read_valid_in = 1'b0; avl_wait_req_in = 1'b0;
        base_addr_in = v.base; num_bursts_in = v.num;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            avl_read_valid_in = 1'b1; avl_rdata_in = 16'hDEAD;
            @(negedge clk);
            check("stray_idle_valid", {31'd0, rd_valid_out}, 32'd0);
        end
        avl_read_valid_in = 1'b0;
        start_trigger = 1'b1;

        while (cyc < 3000 && !(done_seen && tail >= 6)) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) start_trigger = 1'b0;
            if (v.retrig && cyc == 60) start_trigger = 1'b1;
            if (v.retrig && cyc == 62) start_trigger = 1'b0;

            if (rd_valid_out) begin
                check("beat_data", {16'd0, rd_data_out}, {16'd0, pat(beats, seed)});
                beats++;
            end
            if (done_out) begin
                dones++;
                if (!done_seen) check("done_with_last_beat", {31'd0, rd_valid_out}, 32'd1);
                done_seen = 1;
            end
            if (done_seen) tail++;

            // Slave beat generator: 1 on, v.gap off.
            avl_read_valid_in = 1'b0;
            if (to_send > 0) begin
                if (gap_cnt == 0) begin
                    avl_read_valid_in = 1'b1;
                    avl_rdata_in = pat(sent, seed);
                    sent++; to_send--;
                    gap_cnt = v.gap;
                end else begin
                    gap_cnt--;
                end
            end

            if (avl_read_out) begin
                rd_hi++;
                if (!in_cmd) begin
                    in_cmd = 1; cmds++;
                    wait_left = v.wait_cyc;
                    exp_addr = ADDR_W'(32'(v.base) + (cmds - 1) * BURST_LEN);
                    if (first_read_cyc < 0) begin
                        first_read_cyc = cyc;
                        check("busy_at_first_cmd", {31'd0, busy_out}, 32'd1);
                    end
                end
                check("cmd_addr", {7'd0, avl_addr_out}, {7'd0, exp_addr});
                check("cmd_size", {24'd0, avl_size_out}, BURST_LEN);
                last_addr = avl_addr_out;
                if (wait_left > 0) begin
                    avl_wait_req_in = 1'b1;
                    wait_left--;
                    if (v.stray) begin
                        avl_read_valid_in = 1'b1;
                        avl_rdata_in = 16'hBAD0;
                    end
                end else begin
                    avl_wait_req_in = 1'b0;
                    in_cmd = 0;
                    to_send = BURST_LEN;
                    gap_cnt = 0;
                end
            end else begin
                avl_wait_req_in = 1'b0;
            end
        end

        avl_read_valid_in = 1'b0;
        check("run_completed", {31'd0, done_seen}, 32'd1);
        check("cmd_count", cmds, v.exp_cmds);
        check("beat_count", beats, v.exp_beats);
        check("done_count", dones, 32'd1);
        check("read_high_cycles", rd_hi, v.exp_cmds * (v.wait_cyc + 1));
        check("last_cmd_addr", {7'd0, last_addr}, {7'd0, v.exp_last_addr});
        check("launch_latency", first_read_cyc, 32'd3);
        check("idle_after_run", {29'd0, busy_out, avl_read_out, rd_valid_out}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{25'h0000100, 16'd1, 0, 0, 1'b0, 1'b0, 25'h0000100, 32, 1};
        vecs[1] = '{25'h0000100, 16'd3, 5, 0, 1'b0, 1'b1, 25'h0000140, 96, 3};
        vecs[2] = '{25'h1FFFFF0, 16'd2, 0, 0, 1'b1, 1'b0, 25'h0000010, 64, 2};
        vecs[3] = '{25'h0000200, 16'd2, 1, 2, 1'b0, 1'b1, 25'h0000220, 64, 2};

        reset = 1'b1; start_trigger = 1'b0; base_addr_in = '0; num_bursts_in = '0;
        avl_wait_req_in = 1'b0; avl_read_valid_in = 1'b0; avl_rdata_in = '0;
        repeat (3) @(negedge clk);
        check("rst_read", {31'd0, avl_read_out}, 32'd0);
        check("rst_addr", {7'd0, avl_addr_out}, 32'd0);
        check("rst_data", {16'd0, rd_data_out}, 32'd0);
        check("rst_valid_busy_done", {29'd0, rd_valid_out, busy_out, done_out}, 32'd0);
        check("rst_size", {24'd0, avl_size_out}, BURST_LEN);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Trigger held high across reset release must not launch.
        start_trigger = 1'b1; reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("held_trigger_no_run", {29'd0, avl_read_out, busy_out, done_out}, 32'd0);
        end
        start_trigger = 1'b0; num_bursts_in = '0; base_addr_in = 25'h555;
        repeat (4) @(negedge clk);
        start_trigger = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("zero_burst_done", {31'd0, done_out}, (k == 3) ? 32'd1 : 32'd0);
            check("zero_burst_no_read", {31'd0, avl_read_out}, 32'd0);
        end
        start_trigger = 1'b0;

        for (int i = 0; i < 4; i++) do_run(vecs[i], i + 1);

        // Reset after beat 10 while the slave keeps sending the remaining 22 beats.
        begin
            int k;
            @(negedge clk);
            base_addr_in = 25'h400; num_bursts_in = 16'd1;
            start_trigger = 1'b0; avl_wait_req_in = 1'b0; avl_read_valid_in = 1'b0;
            repeat (4) @(negedge clk);
            start_trigger = 1'b1;
            k = 0;
            while (!avl_read_out && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("abort_launch", {31'd0, avl_read_out}, 32'd1);
            start_trigger = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                avl_read_valid_in = 1'b1; avl_rdata_in = pat(i, 9);
                @(negedge clk);
                check("abort_pre_beat", {16'd0, rd_data_out}, {16'd0, pat(i, 9)});
            end
            for (int i = 0; i < 22; i++) begin
                reset = (i < 2);
                avl_read_valid_in = 1'b1; avl_rdata_in = pat(i + 10, 9);
                @(negedge clk);
                check("abort_quiet", {28'd0, rd_valid_out, done_out, avl_read_out, busy_out},
                      32'd0);
                if (i == 0) begin
                    check("abort_rst_addr", {7'd0, avl_addr_out}, 32'd0);
                    check("abort_rst_data", {16'd0, rd_data_out}, 32'd0);
                end
            end
            reset = 1'b0; avl_read_valid_in = 1'b0;
        end

        do_run(vecs[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
